// File: rtl/fetch_pkg.sv
// Shared constants for the fetch sequencer: state encoding, program entry points
// and the branch-target table that the assembler flow regenerates.
package fetch_pkg;

   localparam int A_W   = 12;
   localparam int LUT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [A_W-1:0] ENTRY_ADDR [4] = '{12'd0, 12'd256, 12'd512, 12'd768};

   localparam logic [A_W-1:0] BR_LUT [32] = '{
      12'd0,    12'd16,   12'd32,   12'd40,   12'd64,   12'd80,   12'd96,   12'd112,
      12'd128,  12'd144,  12'd160,  12'd176,  12'd192,  12'd208,  12'd224,  12'd240,
      12'd260,  12'd300,  12'd512,  12'd600,  12'd700,  12'd800,  12'd900,  12'd1000,
      12'd1024, 12'd2048, 12'd3000, 12'd3500, 12'd4000, 12'd4090, 12'd4094, 12'd4095
   };

endpackage

// File: rtl/fetch_ctrl_branch_lut.sv
// Combinational branch-target lookup: instruction LUT index to absolute PC.
module branch_lut
   import fetch_pkg::*;
(
   input  logic [LUT_W-1:0] i_lut_idx,
   output logic [A_W-1:0]   o_target
);

   assign o_target = BR_LUT[i_lut_idx];

endmodule

// File: rtl/fetch_ctrl.sv
// PC / fetch sequencer: launches a program from an entry point, steps, branches,
// stalls and halts, and counts RUN cycles with a saturating counter.
module fetch_ctrl #(
   parameter int A_W   = fetch_pkg::A_W,
   parameter int LUT_W = fetch_pkg::LUT_W,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [1:0]       i_prog_sel,
   input  logic             i_stall,
   input  logic             i_halt,
   input  logic             i_branch_en,
   input  logic             i_branch_taken,
   input  logic [LUT_W-1:0] i_lut_idx,
   output logic [A_W-1:0]   o_prog_ctr,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_cycle_count
);
   import fetch_pkg::*;

   state_t           r_state, w_state_nxt;
   logic [A_W-1:0]   r_pc, w_pc_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [fetch_pkg::A_W-1:0] w_target;

   branch_lut u_lut (
      .i_lut_idx (i_lut_idx),
      .o_target  (w_target)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_pc    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_nxt = RUN;
               w_pc_nxt    = A_W'(ENTRY_ADDR[i_prog_sel]);
               w_cnt_nxt   = '0;
            end
         end
         RUN: begin
            // Stalled and halting edges still count as executed cycles.
            if (r_cnt != {CNT_W{1'b1}})
               w_cnt_nxt = r_cnt + CNT_W'(1);
            if (!i_stall) begin
               if (i_halt)
                  w_state_nxt = DONE;
               else if (i_branch_en && i_branch_taken)
                  w_pc_nxt = A_W'(w_target);
               else
                  w_pc_nxt = r_pc + A_W'(1);
            end
         end
         DONE: begin
            if (!i_start)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_prog_ctr    = r_pc;
   assign o_busy        = (r_state == RUN);
   assign o_done        = (r_state == DONE);
   assign o_cycle_count = r_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table for the main sequence plus
// hand-written wrap and counter-saturation sequences on a narrow-counter copy.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, stall, halt, br_en, br_tk;
   logic [1:0]  prog_sel;
   logic [4:0]  lut_idx;
   logic [11:0] pc, pc4;
   logic        busy, done, busy4, done4;
   logic [15:0] cnt;
   logic [3:0]  cnt4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_prog_sel(prog_sel),
      .i_stall(stall), .i_halt(halt), .i_branch_en(br_en), .i_branch_taken(br_tk),
      .i_lut_idx(lut_idx), .o_prog_ctr(pc), .o_busy(busy), .o_done(done),
      .o_cycle_count(cnt)
   );

   fetch_ctrl #(.CNT_W(4)) dut4 (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_prog_sel(prog_sel),
      .i_stall(stall), .i_halt(halt), .i_branch_en(br_en), .i_branch_taken(br_tk),
      .i_lut_idx(lut_idx), .o_prog_ctr(pc4), .o_busy(busy4), .o_done(done4),
      .o_cycle_count(cnt4)
   );

   typedef struct {
      logic        rst, st;
      logic [1:0]  sel;
      logic        stl, hlt, ben, btk;
      logic [4:0]  idx;
      logic [11:0] e_pc;
      logic        e_busy, e_done;
      int          e_cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, st, input logic [1:0] sel,
                      input logic stl, hlt, ben, btk, input logic [4:0] idx,
                      input int e_pc, input logic e_busy, e_done, input int e_cnt);
      vec_t v;
      v.rst = rst; v.st = st; v.sel = sel; v.stl = stl; v.hlt = hlt;
      v.ben = ben; v.btk = btk; v.idx = idx; v.e_pc = 12'(e_pc);
      v.e_busy = e_busy; v.e_done = e_done; v.e_cnt = e_cnt;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, st, input logic [1:0] sel,
                        input logic stl, hlt, ben, btk, input logic [4:0] idx);
      reset = rst; start = st; prog_sel = sel; stall = stl;
      halt = hlt; br_en = ben; br_tk = btk; lut_idx = idx;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; prog_sel = 2'd0; stall = 1'b0;
      halt = 1'b0; br_en = 1'b0; br_tk = 1'b0; lut_idx = 5'd0;

      //   rst st sel stl hlt ben btk idx  | pc  busy done cnt
      add(1, 0, 0, 0, 0, 0, 0, 0,    0,   0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0,    0,   0, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0, 0,    0,   0, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0, 0,    256, 1, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0,    257, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0,    258, 1, 0, 2);
      add(0, 0, 0, 0, 0, 1, 1, 17,   300, 1, 0, 3);
      add(0, 0, 0, 0, 0, 1, 1, 3,    40,  1, 0, 4);
      add(0, 0, 0, 0, 0, 1, 1, 17,   300, 1, 0, 5);
      add(0, 0, 0, 0, 0, 1, 0, 3,    301, 1, 0, 6);
      add(0, 0, 0, 1, 1, 1, 1, 3,    301, 1, 0, 7);
      add(0, 0, 0, 1, 1, 1, 1, 3,    301, 1, 0, 8);
      add(0, 0, 0, 1, 1, 1, 1, 3,    301, 1, 0, 9);
      add(0, 0, 0, 0, 1, 0, 0, 0,    301, 0, 1, 10);
      add(0, 1, 0, 0, 0, 0, 0, 0,    301, 0, 1, 10);
      add(0, 0, 0, 0, 0, 0, 0, 0,    301, 0, 0, 10);
      add(0, 0, 0, 0, 0, 0, 0, 0,    301, 0, 0, 10);
      add(0, 1, 1, 0, 0, 0, 0, 0,    256, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0,    257, 1, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0,    258, 1, 0, 2);
      add(0, 0, 0, 0, 0, 0, 0, 0,    259, 1, 0, 3);
      add(0, 0, 0, 0, 0, 0, 0, 0,    260, 1, 0, 4);
      add(0, 0, 0, 0, 1, 0, 0, 0,    260, 0, 1, 5);
      add(0, 1, 0, 0, 0, 0, 0, 0,    260, 0, 1, 5);
      add(0, 1, 0, 0, 0, 0, 0, 0,    260, 0, 1, 5);
      add(0, 1, 0, 0, 0, 0, 0, 0,    260, 0, 1, 5);
      add(0, 1, 0, 0, 0, 0, 0, 0,    260, 0, 1, 5);
      add(0, 0, 0, 0, 0, 0, 0, 0,    260, 0, 0, 5);
      add(0, 1, 2, 0, 0, 0, 0, 0,    512, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0,    513, 1, 0, 1);
      add(0, 0, 0, 0, 0, 1, 1, 18,   512, 1, 0, 2);
      add(1, 1, 3, 0, 0, 0, 0, 0,    0,   0, 0, 0);
      add(1, 1, 3, 0, 0, 0, 0, 0,    0,   0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0,    0,   0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].st, tbl[i].sel, tbl[i].stl, tbl[i].hlt,
               tbl[i].ben, tbl[i].btk, tbl[i].idx);
         check($sformatf("row%0d pc", i),   int'(pc),   int'(tbl[i].e_pc));
         check($sformatf("row%0d busy", i), int'(busy), int'(tbl[i].e_busy));
         check($sformatf("row%0d done", i), int'(done), int'(tbl[i].e_done));
         check($sformatf("row%0d cnt", i),  int'(cnt),  tbl[i].e_cnt);
         check($sformatf("row%0d cnt4", i), int'(cnt4),
               (tbl[i].e_cnt > 15) ? 15 : tbl[i].e_cnt);
      end

      // Wrap: launch at 0, branch to 4095, then a plain step rolls over to 0.
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      check("wrap launch pc", int'(pc), 0);
      drive(0, 0, 0, 0, 0, 1, 1, 31);
      check("wrap branch pc", int'(pc), 4095);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check("wrap pc", int'(pc), 0);
      check("wrap busy", int'(busy), 1);
      check("wrap cnt", int'(cnt), 2);

      // Saturation: 20 more RUN edges; narrow counter pins at 15.
      for (int k = 1; k <= 20; k++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         check($sformatf("sat%0d cnt4", k), int'(cnt4), (k + 2 > 15) ? 15 : k + 2);
      end
      check("sat cnt16", int'(cnt), 22);
      check("sat pc", int'(pc), 20);
      check("sat pc4", int'(pc4), 20);

      // Halt with saturated counter: both counters hold in DONE.
      drive(0, 0, 0, 0, 1, 0, 0, 0);
      check("sat halt done", int'(done4), 1);
      check("sat halt cnt4", int'(cnt4), 15);
      check("sat halt cnt", int'(cnt), 23);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
